dadda_mac_acc: RTL and testbench

DADDA_MAC_ACC -- requirements
Module: dadda_mac_acc

---
 rtl/dadda_mac_pkg.sv | 14 +
 rtl/dadda_8.sv | 110 +++++++++++
 rtl/dadda_mac_acc.sv | 136 +++++++++++++
 tb/tb_dadda_mac_acc.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dadda_mac_pkg.sv
// Shared types and constants for the Dadda multiply-accumulate block.
package dadda_mac_pkg;

   localparam int PROD_W    = 16;
   localparam int ACC_W_DEF = 20;
   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      ACC   = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/dadda_8.sv
// 8x8 unsigned Dadda multiplier: partial-product columns are reduced to
// heights 6, 4, 3, 2 with half/full adders, then summed by a final adder.
module dadda_8 (
   input  logic [7:0]  A,
   input  logic [7:0]  B,
   output logic [15:0] y
);

   localparam int NCOL  = 16;
   localparam int DEPTH = 16;
   localparam logic [3:0] D_TAB [4] = '{4'd6, 4'd4, 4'd3, 4'd2};

   // column NCOL is a sink for carries out of the top column (always zero)
   logic        cur_s  [NCOL+1][DEPTH];
   logic        nxt_s  [NCOL+1][DEPTH];
   logic [3:0]  hc_s   [NCOL+1];
   logic [3:0]  hn_s   [NCOL+1];
   logic [3:0]  k_s;
   logic [3:0]  rem_s;
   logic [4:0]  live_s;
   logic [3:0]  d_s;
   logic        x_s, y_s, z_s;
   logic [15:0] row0_s, row1_s;

   // partial-product generation and column-wise Dadda reduction
   always_comb begin
      for (int c = 0; c <= NCOL; c++) begin
         hc_s[c] = 4'd0;
         hn_s[c] = 4'd0;
         for (int j = 0; j < DEPTH; j++) begin
            cur_s[c][j] = 1'b0;
            nxt_s[c][j] = 1'b0;
         end
      end
      k_s    = 4'd0;
      rem_s  = 4'd0;
      live_s = 5'd0;
      d_s    = 4'd0;
      x_s    = 1'b0;
      y_s    = 1'b0;
      z_s    = 1'b0;
      row0_s = 16'd0;
      row1_s = 16'd0;

      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            cur_s[i+j][hc_s[i+j]] = A[i] & B[j];
            hc_s[i+j]             = hc_s[i+j] + 4'd1;
         end
      end

      for (int s = 0; s < 4; s++) begin
         d_s = D_TAB[s];
         for (int c = 0; c <= NCOL; c++) begin
            hn_s[c] = 4'd0;
            for (int j = 0; j < DEPTH; j++) begin
               nxt_s[c][j] = 1'b0;
            end
         end
         for (int c = 0; c < NCOL; c++) begin
            k_s = 4'd0;
            // compress only as far as needed to reach the stage target height
            for (int it = 0; it < 8; it++) begin
               rem_s  = hc_s[c] - k_s;
               live_s = {1'b0, rem_s} + {1'b0, hn_s[c]};
               x_s    = cur_s[c][k_s];
               y_s    = cur_s[c][k_s + 4'd1];
               z_s    = cur_s[c][k_s + 4'd2];
               if ((live_s > ({1'b0, d_s} + 5'd1)) && (rem_s >= 4'd3)) begin
                  nxt_s[c][hn_s[c]]     = x_s ^ y_s ^ z_s;
                  hn_s[c]               = hn_s[c] + 4'd1;
                  nxt_s[c+1][hn_s[c+1]] = (x_s & y_s) | (x_s & z_s) | (y_s & z_s);
                  hn_s[c+1]             = hn_s[c+1] + 4'd1;
                  k_s                   = k_s + 4'd3;
               end else if ((live_s > {1'b0, d_s}) && (rem_s >= 4'd2)) begin
                  nxt_s[c][hn_s[c]]     = x_s ^ y_s;
                  hn_s[c]               = hn_s[c] + 4'd1;
                  nxt_s[c+1][hn_s[c+1]] = x_s & y_s;
                  hn_s[c+1]             = hn_s[c+1] + 4'd1;
                  k_s                   = k_s + 4'd2;
               end else begin
                  k_s = k_s;
               end
            end
            for (int j = 0; j < DEPTH; j++) begin
               if ((4'(j) >= k_s) && (4'(j) < hc_s[c])) begin
                  nxt_s[c][hn_s[c]] = cur_s[c][j];
                  hn_s[c]           = hn_s[c] + 4'd1;
               end else begin
                  hn_s[c] = hn_s[c];
               end
            end
         end
         for (int c = 0; c <= NCOL; c++) begin
            hc_s[c] = hn_s[c];
            for (int j = 0; j < DEPTH; j++) begin
               cur_s[c][j] = nxt_s[c][j];
            end
         end
      end

      for (int c = 0; c < NCOL; c++) begin
         row0_s[c] = cur_s[c][0];
         row1_s[c] = cur_s[c][1];
      end
   end

   assign y = row0_s + row1_s;

endmodule

// File: rtl/dadda_mac_acc.sv
// Multiply-accumulate over dot-product vectors: a registered operand stage
// feeds the Dadda multiplier, whose product is added into a wrapping accumulator.
module dadda_mac_acc
   import dadda_mac_pkg::*;
#(
   parameter int ACC_W = ACC_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       A,
   input  logic [7:0]       B,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic [CNT_W-1:0] cnt_out,
   output logic             ovf
);

   state_e             state_q, state_d;
   logic [7:0]         op_a_q, op_a_d;
   logic [7:0]         op_b_q, op_b_d;
   logic               op_last_q, op_last_d;
   logic               op_v_q, op_v_d;
   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic               out_valid_q, out_valid_d;
   logic               accept_s;
   logic [PROD_W-1:0]  product_s;
   logic [ACC_W:0]     sum_s;

   dadda_8 u_mult (
      .A (op_a_q),
      .B (op_b_q),
      .y (product_s)
   );

   assign in_ready = (state_q == ACC);
   assign accept_s = in_valid && in_ready;
   assign sum_s    = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, product_s};

   // operand capture, accumulation and vector control
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      ovf_d     = ovf_q;
      op_a_d    = op_a_q;
      op_b_d    = op_b_q;
      op_last_d = op_last_q;
      op_v_d    = accept_s;

      if (accept_s) begin
         op_a_d    = A;
         op_b_d    = B;
         op_last_d = in_last;
      end else begin
         op_last_d = op_last_q;
      end

      if (op_v_q) begin
         acc_d = sum_s[ACC_W-1:0];
         ovf_d = ovf_q | sum_s[ACC_W];
         if (cnt_q == {CNT_W{1'b1}}) begin
            cnt_d = cnt_q;
         end else begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end else begin
         acc_d = acc_q;
      end

      case (state_q)
         ACC: begin
            if (accept_s && in_last) begin
               state_d = FLUSH;
            end else begin
               state_d = ACC;
            end
         end
         FLUSH: begin
            state_d = DONE;
         end
         DONE: begin
            if (out_valid_q && out_ready) begin
               state_d = ACC;
               acc_d   = {ACC_W{1'b0}};
               cnt_d   = {CNT_W{1'b0}};
               ovf_d   = 1'b0;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = ACC;
         end
      endcase

      out_valid_d = (state_d == DONE);
   end

   // state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACC;
         op_a_q      <= 8'd0;
         op_b_q      <= 8'd0;
         op_last_q   <= 1'b0;
         op_v_q      <= 1'b0;
         acc_q       <= {ACC_W{1'b0}};
         cnt_q       <= {CNT_W{1'b0}};
         ovf_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_last_q   <= op_last_d;
         op_v_q      <= op_v_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign acc_out   = acc_q;
   assign cnt_out   = cnt_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_dadda_mac_acc.sv
// Randomised bench for dadda_mac_acc against a sum-of-products reference model.
module tb_dadda_mac_acc;

   localparam int ACC_W = 20;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [7:0]       a_s = 8'd0;
   logic [7:0]       b_s = 8'd0;
   logic             in_last = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [ACC_W-1:0] acc_out;
   logic [CNT_W-1:0] cnt_out;
   logic             ovf;

   typedef struct {
      longint acc;
      longint cnt;
      longint ovf;
   } exp_t;

   exp_t exp_q[$];
   int   va[$];
   int   vb[$];
   int   checks = 0;
   int   errors = 0;

   dadda_mac_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (a_s),
      .B         (b_s),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .acc_out   (acc_out),
      .cnt_out   (cnt_out),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // result of the vector held in va/vb, from plain arithmetic
   function automatic exp_t model_of();
      exp_t   e;
      longint sum = 0;
      foreach (va[i]) sum += longint'(va[i]) * longint'(vb[i]);
      e.acc = sum % (longint'(1) << ACC_W);
      e.cnt = (va.size() > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : va.size();
      e.ovf = (sum >= (longint'(1) << ACC_W)) ? 1 : 0;
      return e;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         in_valid = 1'b0;
         a_s      = 8'($urandom);
         b_s      = 8'($urandom);
         in_last  = 1'($urandom);
         @(posedge clk);
         #1;
      end
      in_last = 1'b0;
   endtask

   task automatic send_pair(input int a, input int b, input logic last);
      chk("in_ready_acc", in_ready, 1);
      in_valid = 1'b1;
      a_s      = 8'(a);
      b_s      = 8'(b);
      in_last  = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_vec(input int hold, input int bub_pct, input bit alt,
                           input bit use_lit, input longint lacc, input longint lcnt,
                           input longint lovf);
      exp_t e;
      int   n;
      e = model_of();
      n = va.size();
      if (use_lit) begin
         chk("model_acc", e.acc, lacc);
         chk("model_cnt", e.cnt, lcnt);
         chk("model_ovf", e.ovf, lovf);
      end
      exp_q.push_back(e);
      for (int i = 0; i < n; i++) begin
         if (alt && i > 0) idle(1);
         else if ($urandom_range(0, 99) < bub_pct) idle($urandom_range(1, 3));
         send_pair(va[i], vb[i], (i == n - 1));
      end
      // garbage offered while the block is busy must be ignored
      in_valid = 1'b1;
      a_s      = 8'($urandom);
      b_s      = 8'($urandom);
      in_last  = 1'($urandom);
      chk("lat_flush_out_valid", out_valid, 0);
      chk("in_ready_flush", in_ready, 0);
      @(posedge clk);
      #1;
      chk("lat_done_out_valid", out_valid, 1);
      if (use_lit) begin
         chk("lit_acc_out", acc_out, lacc);
         chk("lit_cnt_out", cnt_out, lcnt);
         chk("lit_ovf", ovf, lovf);
      end
      repeat (hold) begin
         @(posedge clk);
         #1;
         chk("in_ready_done", in_ready, 0);
         chk("hold_out_valid", out_valid, 1);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      chk("clr_out_valid", out_valid, 0);
      chk("clr_acc_out", acc_out, 0);
      chk("clr_cnt_out", cnt_out, 0);
      chk("clr_ovf", ovf, 0);
      chk("clr_in_ready", in_ready, 1);
      va.delete();
      vb.delete();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"}, in_ready, 1);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_acc_out"}, acc_out, 0);
      chk({tag, "_cnt_out"}, cnt_out, 0);
      chk({tag, "_ovf"}, ovf, 0);
   endtask

   // compare process: every cycle a result is presented it must match the model
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
         end else begin
            chk("mon_acc_out", acc_out, exp_q[0].acc);
            chk("mon_cnt_out", cnt_out, exp_q[0].cnt);
            chk("mon_ovf", ovf, exp_q[0].ovf);
            chk("mon_in_ready", in_ready, 0);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      exp_t e;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      va = '{3, 7};  vb = '{5, 9};
      send_vec(0, 0, 0, 1, 78, 2, 0);

      va = '{255};   vb = '{255};
      send_vec(1, 0, 0, 1, 65025, 1, 0);

      repeat (17) begin va.push_back(255); vb.push_back(255); end
      send_vec(0, 0, 0, 1, 56849, 17, 1);

      repeat (16) begin va.push_back(255); vb.push_back(255); end
      send_vec(0, 0, 0, 1, 1040400, 16, 0);

      va = '{11};    vb = '{13};
      send_vec(5, 0, 0, 1, 143, 1, 0);
      va = '{2};     vb = '{2};
      send_vec(0, 0, 0, 1, 4, 1, 0);

      va = '{1, 2, 3}; vb = '{1, 2, 3};
      send_vec(0, 0, 1, 1, 14, 3, 0);

      // reset in the middle of a vector
      send_pair(9, 9, 1'b0);
      send_pair(8, 8, 1'b0);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("mid_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(2);
      va = '{4};     vb = '{4};
      send_vec(0, 0, 0, 1, 16, 1, 0);

      // reset while a result is pending
      va = '{20, 30}; vb = '{40, 50};
      e = model_of();
      exp_q.push_back(e);
      send_pair(20, 40, 1'b0);
      send_pair(30, 50, 1'b1);
      @(posedge clk);
      #1;
      chk("pend_out_valid", out_valid, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk_reset_outputs("done_rst");
      exp_q.delete();
      va.delete();
      vb.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(3);

      // long vector: count saturates, accumulator wraps repeatedly
      repeat (300) begin
         va.push_back($urandom_range(0, 255));
         vb.push_back($urandom_range(0, 255));
      end
      send_vec(1, 10, 0, 0, 0, 0, 0);

      for (int v = 0; v < 40; v++) begin
         int n;
         bit big;
         n   = $urandom_range(1, 24);
         big = ($urandom_range(0, 1) == 1);
         repeat (n) begin
            va.push_back(big ? $urandom_range(200, 255) : $urandom_range(0, 255));
            vb.push_back(big ? $urandom_range(200, 255) : $urandom_range(0, 255));
         end
         send_vec($urandom_range(0, 3), 30, 0, 0, 0, 0, 0);
         idle($urandom_range(0, 2));
      end

      chk("results_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
